ras_ctrl: RTL

Return-address-stack controller sitting directly upstream of the `reg_stack` return address stack in the fetch/decode path. Turns decoded call/return events into push/pop commands. Redirects fetch to the predicted return target after the MIPS delay slot. Checks each prediction against the target resolved in EX, and clears the stack on a mispredict.

---
 rtl/ras_pkg.sv | 27 ++
 rtl/ras_pend_fifo.sv | 69 ++++++
 rtl/ras_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ras_pkg.sv
// ============================================================================
// Module  : ras_pkg
// Purpose : Shared types and constants for the return-address-stack controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ras_pkg;

    // Pending entries are stored at this width and zero-extended from ADDR_W.
    localparam int RAS_MAX_ADDR_W = 64;
    localparam int RET_OFFSET     = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DS_WAIT = 2'd1,
        REDIR   = 2'd2
    } ras_state_e;

    typedef struct packed {
        logic                      has_pred;
        logic [RAS_MAX_ADDR_W-1:0] target;
    } pend_entry_t;

endpackage

`default_nettype wire

// File: rtl/ras_pend_fifo.sv
// ============================================================================
// Module  : ras_pend_fifo
// Purpose : Circular FIFO of in-flight return predictions awaiting EX resolution.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ras_pend_fifo
    import ras_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_wr,
    input  pend_entry_t i_wr_data,
    input  logic        i_rd,
    output pend_entry_t o_rd_data,
    output logic        o_full,
    output logic        o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    pend_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_do_rd;
    logic              w_do_wr;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_data = r_mem[r_rd_ptr];

    // A read in the same cycle frees a slot, so a write at full still lands.
    assign w_do_rd = i_rd & ~o_empty;
    assign w_do_wr = i_wr & (~o_full | w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ras_ctrl.sv
// ============================================================================
// Module  : ras_ctrl
// Purpose : Drives the return address stack from decoded call/return events,
//           redirects fetch after the delay slot and checks predictions in EX.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ras_ctrl
    import ras_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int PEND_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_call,
    input  logic              id_ret,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [ADDR_W-1:0] ras_top,
    input  logic              ras_empty,
    output logic              ras_push,
    output logic              ras_pop,
    output logic [ADDR_W-1:0] ras_data,
    output logic              ras_clear,
    input  logic              ex_ret_valid,
    input  logic [ADDR_W-1:0] ex_ret_target,
    output logic              pred_valid,
    output logic [ADDR_W-1:0] pred_target,
    output logic              mispredict,
    output logic              err_overflow
);

    ras_state_e        r_state;
    ras_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_target;
    logic              r_mis;
    logic              r_err;

    logic              w_acc;
    logic              w_idle;
    logic              w_ret_idle;
    logic              w_deq;
    logic              w_pend_full;
    logic              w_enq;
    logic              w_mis;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    pend_entry_t       w_enq_entry;
    pend_entry_t       w_head;

    // The REDIR slot is squashed downstream, so nothing in ID counts then.
    assign w_idle     = (r_state == IDLE);
    assign w_acc      = id_valid & ~flush & ~reset & (r_state != REDIR);
    assign w_ret_idle = w_acc & id_ret & w_idle;

    assign w_deq       = ex_ret_valid & ~flush & ~reset & ~w_fifo_empty;
    assign w_pend_full = w_fifo_full & ~w_deq;
    assign w_enq       = w_ret_idle & ~w_pend_full;

    assign w_enq_entry.has_pred = ~ras_empty;
    assign w_enq_entry.target   = RAS_MAX_ADDR_W'(ras_top);

    assign w_mis = w_deq & w_head.has_pred &
                   (w_head.target != RAS_MAX_ADDR_W'(ex_ret_target));

    assign ras_push = w_acc & id_call & w_idle;
    assign ras_pop  = w_ret_idle & ~ras_empty & ~w_pend_full;
    assign ras_data = ras_push ? (id_pc + ADDR_W'(RET_OFFSET)) : '0;

    assign pred_valid   = (r_state == REDIR) & ~flush & ~reset;
    assign pred_target  = pred_valid ? r_target : '0;
    assign mispredict   = r_mis & ~reset;
    assign ras_clear    = r_mis & ~reset;
    assign err_overflow = r_err & ~reset;

    ras_pend_fifo #(
        .DEPTH (PEND_DEPTH)
    ) u_pend_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (flush | w_mis),
        .i_wr      (w_enq),
        .i_wr_data (w_enq_entry),
        .i_rd      (w_deq),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_enq && !ras_empty) w_state_nxt = DS_WAIT;
            DS_WAIT: if (w_acc)               w_state_nxt = REDIR;
            REDIR:                            w_state_nxt = IDLE;
            default:                          w_state_nxt = IDLE;
        endcase
        if (flush || w_mis) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_mis    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mis   <= w_mis;
            if (w_idle && w_enq && !ras_empty) begin
                r_target <= ras_top;
            end
            if (w_ret_idle && w_pend_full) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
